// File: rtl/fifo_rd_sched.sv
// -----------------------------------------------------------------------------
// fifo_rd_sched
// Round-robin read scheduler sharing the read port of an async FIFO among
// NREQ consumers. It runs in the read-clock domain, consumes the registered
// empty flag of the read-pointer logic and drives its pop strobe. Each grant
// is a burst of up to burst_len+1 beats with a per-beat valid/ready handshake.
//
// Ports:
//   rclk       read-domain clock
//   rrst_n     asynchronous active-low reset
//   req        per-consumer request (level)
//   burst_len  per-consumer burst length field, consumer i at [i*BURST_W +: BURST_W]
//   ready      per-consumer beat accept
//   empty      FIFO empty flag (registered)
//   rdata      FIFO read data, valid whenever empty=0
//   r_en       FIFO pop strobe (one per accepted beat)
//   gnt        one-hot registered grant
//   out_valid  beat valid to the granted consumer
//   out_data   beat data (pass-through of rdata)
//   out_last   final beat of the burst
//   busy       high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_rd_sched #(
   parameter int NREQ       = 4,
   parameter int BURST_W    = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    rclk,
   input  logic                    rrst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*BURST_W-1:0] burst_len,
   input  logic [NREQ-1:0]         ready,
   input  logic                    empty,
   input  logic [DATA_WIDTH-1:0]   rdata,
   output logic                    r_en,
   output logic [NREQ-1:0]         gnt,
   output logic                    out_valid,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t             state_q, state_d;
   logic [NREQ-1:0]    gnt_q, gnt_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]   sel_q, sel_d;
   logic [BURST_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [BURST_W-1:0] len_q, len_d;

   logic [BURST_W-1:0] len_arr [NREQ];
   logic               pick_found;
   logic [PTR_W-1:0]   pick_idx;
   logic               hs;

   for (genvar i = 0; i < NREQ; i++) begin : g_len
      assign len_arr[i] = burst_len[i*BURST_W +: BURST_W];
   end

   // Round-robin pick: first asserted request scanning rr_ptr, rr_ptr+1, ...
   // with an explicit wrap so non-power-of-two NREQ works too.
   always_comb begin
      int               idx;
      logic [PTR_W-1:0] cand;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      cand       = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = PTR_W'(idx);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_ptr_d   = rr_ptr_q;
      sel_d      = sel_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      busy       = (state_q == BURST);
      out_data   = rdata;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      hs         = 1'b0;

      case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (pick_found) begin
               state_d    = BURST;
               gnt_d      = NREQ'(1) << pick_idx;
               sel_d      = pick_idx;
               len_d      = len_arr[pick_idx];
               beat_cnt_d = '0;
               rr_ptr_d   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
            end
         end
         BURST: begin
            out_valid = ~empty;
            out_last  = out_valid & (beat_cnt_q == len_q);
            hs        = out_valid & ready[sel_q];
            if (hs) begin
               // The beat is always taken; a dropped request ends the burst
               // after it. Compare-before-increment keeps all-ones lengths safe.
               if ((beat_cnt_q == len_q) || !req[sel_q]) begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end else begin
                  beat_cnt_d = beat_cnt_q + BURST_W'(1);
               end
            end else if (!req[sel_q]) begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   assign r_en = hs;
   assign gnt  = gnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values of the others.
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         rr_ptr_q   <= '0;
         sel_q      <= '0;
         beat_cnt_q <= '0;
         len_q      <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rr_ptr_q   <= rr_ptr_d;
         sel_q      <= sel_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
      end
   end

endmodule

// File: tb/tb_fifo_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_sched
// Self-checking bench for fifo_rd_sched. A simple FIFO stand-in (array plus
// read/write counters) feeds empty/rdata. A transaction-level reference model
// (current owner, beats remaining, next search start) predicts gnt, out_valid,
// out_last, r_en, busy and out_data every cycle; hand-written sequences and a
// vector table add fixed expectations for the directed corner cases.
// -----------------------------------------------------------------------------
module tb_fifo_rd_sched;

   localparam int NREQ = 4;
   localparam int BW   = 4;
   localparam int DW   = 8;

   logic             rclk = 1'b0;
   logic             rrst_n;
   logic [NREQ-1:0]  req;
   logic [NREQ-1:0]  ready;
   logic [NREQ*BW-1:0] burst_len;
   logic             empty;
   logic [DW-1:0]    rdata;
   logic             r_en;
   logic [NREQ-1:0]  gnt;
   logic             out_valid;
   logic [DW-1:0]    out_data;
   logic             out_last;
   logic             busy;

   fifo_rd_sched #(.NREQ(NREQ), .BURST_W(BW), .DATA_WIDTH(DW)) dut (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .req       (req),
      .burst_len (burst_len),
      .ready     (ready),
      .empty     (empty),
      .rdata     (rdata),
      .r_en      (r_en),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 rclk = ~rclk;

   // FIFO stand-in: the DUT's pops advance rd_cnt, the bench's pushes wr_cnt.
   logic [DW-1:0] mem [256];
   logic [7:0]    rd_cnt = 8'd0;
   logic [7:0]    wr_cnt = 8'd0;

   always @(posedge rclk) if (r_en) rd_cnt <= rd_cnt + 8'd1;
   assign empty = (rd_cnt == wr_cnt);
   assign rdata = mem[rd_cnt];

   // Reference model state
   int         m_owner;   // granted consumer, -1 when none
   int         m_left;    // beats still owed in the current burst
   int         m_next;    // where the next search starts
   logic [7:0] m_rd = 8'd0; // expected FIFO read position

   int n_pass = 0;
   int n_chk  = 0;

   // Outputs as observed in the most recent cycle
   logic [NREQ-1:0] s_gnt;
   logic            s_valid, s_last, s_ren, s_busy;
   logic [DW-1:0]   s_data;

   typedef struct {
      logic [3:0] req;
      logic [3:0] ready;
      logic [3:0] gnt;
      logic       valid;
      logic       last;
      logic       ren;
      logic [7:0] data;
   } vec_t;

   vec_t tbl [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic m_reset();
      m_owner = -1;
      m_left  = 0;
      m_next  = 0;
   endtask

   function automatic int lane_len(input int i);
      logic [BW-1:0] f;
      f = burst_len[i*BW +: BW];
      return int'(f);
   endfunction

   task automatic push(input logic [DW-1:0] d);
      mem[wr_cnt] = d;
      wr_cnt      = wr_cnt + 8'd1;
   endtask

   task automatic flush();
      wr_cnt = m_rd;
   endtask

   task automatic set_len(input int i, input logic [BW-1:0] v);
      burst_len[i*BW +: BW] = v;
   endtask

   // One clock: compare outputs against the model mid-cycle, then advance the
   // model with the inputs seen at the edge. Returns at posedge + 1.
   task automatic cycle();
      logic [NREQ-1:0] e_gnt;
      logic            e_valid, e_last, e_ren;
      logic [1:0]      o;
      int              i;
      @(negedge rclk);
      if (!rrst_n) m_reset();
      o       = m_owner[1:0];
      e_gnt   = (m_owner < 0) ? '0 : NREQ'(1) << m_owner;
      e_valid = (m_owner >= 0) && (m_rd != wr_cnt);
      e_last  = e_valid && (m_left == 1);
      e_ren   = e_valid && ready[o];
      s_gnt = gnt; s_valid = out_valid; s_last = out_last;
      s_ren = r_en; s_busy = busy; s_data = out_data;
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out_last", 32'(out_last), 32'(e_last));
      check("r_en", 32'(r_en), 32'(e_ren));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      if (e_valid) check("out_data", 32'(out_data), 32'(mem[m_rd]));
      @(posedge rclk);
      if (!rrst_n) begin
         m_reset();
      end else if (m_owner < 0) begin
         for (int k = 0; k < NREQ; k++) begin
            i = (m_next + k) % NREQ;
            if (m_owner < 0 && req[i[1:0]]) begin
               m_owner = i;
               m_left  = lane_len(i) + 1;
               m_next  = (i + 1) % NREQ;
            end
         end
      end else begin
         if (e_ren) begin
            m_rd   = m_rd + 8'd1;
            m_left = m_left - 1;
            if (m_left == 0 || !req[o]) m_owner = -1;
         end else if (!req[o]) begin
            m_owner = -1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      cycle();
      rrst_n = 1'b1;
      flush();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd0;
      int         pops;

      // Scenario 1 (entries 0-6): burst of 3 to consumer 0, then rr_ptr=1 check.
      tbl[0]  = '{4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b1, 8'hA1};
      tbl[2]  = '{4'h1, 4'h1, 4'h1, 1'b1, 1'b0, 1'b1, 8'hB2};
      tbl[3]  = '{4'h1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1, 8'hC3};
      tbl[4]  = '{4'h0, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[5]  = '{4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[6]  = '{4'hF, 4'h0, 4'h2, 1'b1, 1'b1, 1'b0, 8'hD4};
      // Scenario 2 (entries 7-16): all requesting, 1-beat bursts with bubbles.
      tbl[7]  = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[8]  = '{4'hF, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 8'h10};
      tbl[9]  = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[10] = '{4'hF, 4'hF, 4'h2, 1'b1, 1'b1, 1'b1, 8'h11};
      tbl[11] = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[12] = '{4'hF, 4'hF, 4'h4, 1'b1, 1'b1, 1'b1, 8'h12};
      tbl[13] = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[14] = '{4'hF, 4'hF, 4'h8, 1'b1, 1'b1, 1'b1, 8'h13};
      tbl[15] = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[16] = '{4'hF, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 8'h14};

      // NOTE: stimulus is driven with blocking assignments just after the
      // clock edge, so the DUT sees stable inputs at the next edge.
      rrst_n = 1'b0; req = '0; ready = '0; burst_len = '0;
      m_reset();
      cycle();
      check("reset_gnt", 32'(s_gnt), 32'h0);
      check("reset_busy", 32'(s_busy), 32'h0);
      check("reset_r_en", 32'(s_ren), 32'h0);
      do_reset();

      set_len(0, 4'd2);
      push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
      for (int v = 0; v < 17; v++) begin
         if (v == 7) begin
            do_reset();
            burst_len = '0;
            for (int k = 0; k < 16; k++) push(8'(8'h10 + k));
         end
         req   = tbl[v].req;
         ready = tbl[v].ready;
         cycle();
         check($sformatf("tbl%0d_gnt", v), 32'(s_gnt), 32'(tbl[v].gnt));
         check($sformatf("tbl%0d_valid", v), 32'(s_valid), 32'(tbl[v].valid));
         check($sformatf("tbl%0d_last", v), 32'(s_last), 32'(tbl[v].last));
         check($sformatf("tbl%0d_r_en", v), 32'(s_ren), 32'(tbl[v].ren));
         if (tbl[v].valid) check($sformatf("tbl%0d_data", v), 32'(s_data), 32'(tbl[v].data));
         if (v == 4) begin
            check("s1_fifo_left", 32'(8'(wr_cnt - rd_cnt)), 32'd1);
            check("s1_head", 32'(rdata), 32'hD4);
         end
      end

      // Scenario 3: burst stalls on empty mid-burst, resumes after writes.
      do_reset();
      burst_len = '0; set_len(1, 4'd3);
      push(8'h30);
      req = 4'b0010; ready = 4'b0010;
      cycle();
      cycle();
      check("s3_first_pop", 32'(s_ren), 32'h1);
      for (int k = 0; k < 2; k++) begin
         cycle();
         check("s3_stall_valid", 32'(s_valid), 32'h0);
         check("s3_stall_gnt", 32'(s_gnt), 32'h2);
      end
      push(8'h31); push(8'h32); push(8'h33);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("s3_pop", 32'(s_ren), 32'h1);
         check("s3_last", 32'(s_last), 32'(k == 2));
      end
      cycle();
      check("s3_done_gnt", 32'(s_gnt), 32'h0);

      // Scenario 4: ready low for 5 cycles with data present.
      do_reset();
      burst_len = '0; set_len(2, 4'd3);
      for (int k = 0; k < 4; k++) push(8'(8'h40 + k));
      req = 4'b0100; ready = 4'b0000;
      cycle();
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("s4_hold_r_en", 32'(s_ren), 32'h0);
         check("s4_hold_data", 32'(s_data), 32'h40);
      end
      ready = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("s4_pop", 32'(s_ren), 32'h1);
         check("s4_data", 32'(s_data), 32'(8'h40 + k));
         check("s4_last", 32'(s_last), 32'(k == 3));
      end

      // Scenario 5: consumer 0 drops its request after 2 of 8 beats.
      do_reset();
      burst_len = '0; set_len(0, 4'd7);
      for (int k = 0; k < 10; k++) push(8'(8'h50 + k));
      req = 4'b0001; ready = 4'b1111;
      rd0 = rd_cnt;
      cycle(); cycle(); cycle();
      req = 4'b1000; ready = 4'b1110;
      cycle();
      check("s5_abort_r_en", 32'(s_ren), 32'h0);
      check("s5_abort_gnt", 32'(s_gnt), 32'h1);
      cycle();
      check("s5_idle_gnt", 32'(s_gnt), 32'h0);
      check("s5_pops", 32'(8'(rd_cnt - rd0)), 32'd2);
      cycle();
      check("s5_next_gnt", 32'(s_gnt), 32'h8);

      // Scenario 7: all-ones length gives 2^BW beats.
      do_reset();
      burst_len = '0; set_len(0, 4'hF);
      for (int k = 0; k < 18; k++) push(8'(8'h70 + k));
      req = 4'b0001; ready = 4'b0001;
      cycle();
      pops = 0;
      for (int k = 0; k < 16; k++) begin
         cycle();
         if (s_ren) pops++;
         if (k < 15) check("s7_not_last", 32'(s_last), 32'h0);
      end
      check("s7_last", 32'(s_last), 32'h1);
      check("s7_pops", 32'(pops), 32'd16);
      cycle();
      check("s7_idle", 32'(s_gnt), 32'h0);

      // Scenario 6: asynchronous reset mid-burst.
      do_reset();
      burst_len = '0; set_len(1, 4'd5);
      for (int k = 0; k < 6; k++) push(8'(8'h60 + k));
      req = 4'b0010; ready = 4'b0010;
      cycle(); cycle();
      check("s6_pre_r_en", 32'(s_ren), 32'h1);
      rrst_n = 1'b0;
      #1;
      check("s6_async_gnt", 32'(gnt), 32'h0);
      check("s6_async_busy", 32'(busy), 32'h0);
      check("s6_async_r_en", 32'(r_en), 32'h0);
      cycle();
      rrst_n = 1'b1;
      req = 4'b1111; ready = 4'b0000;
      cycle();
      check("s6_idle_gnt", 32'(s_gnt), 32'h0);
      cycle();
      check("s6_first_gnt", 32'(s_gnt), 32'h1);

      // Randomised phase against the model.
      do_reset();
      req = '0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) req = req ^ NREQ'($urandom);
         ready = NREQ'($urandom);
         if ($urandom_range(0, 9) == 0) burst_len = (NREQ*BW)'($urandom);
         if (8'(wr_cnt - m_rd) < 8'd200 && $urandom_range(0, 2) != 0) push(DW'($urandom));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
